// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the CPU datapath:
// IR/handshake inputs toward the sequencer, strobes and ALU op back out.
interface control_sequencer_if #(
    parameter int OPW   = 5,
    parameter int STEPW = 4
);
    logic [31:0]      ir;
    logic             mem_ready;
    logic             stop;
    logic             run;
    logic [STEPW-1:0] step;
    logic [OPW-1:0]   alu_op;
    logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, BAout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin;
    logic IncPC, Read, Write, Gra, Grb, Grc, Rout;

    modport master (
        input  ir, mem_ready, stop,
        output run, step, alu_op,
        output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, BAout,
        output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin,
        output IncPC, Read, Write, Gra, Grb, Grc, Rout
    );

    modport slave (
        output ir, mem_ready, stop,
        input  run, step, alu_op,
        input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, BAout,
        input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin,
        input  IncPC, Read, Write, Gra, Grb, Grc, Rout
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps fetch T0-T2 and execute T3-T7, stalls on
// mem_ready, and handles pause/halt. Strobes are a Moore decode of step + IR.
module control_sequencer #(
    parameter int OPW   = 5,
    parameter int STEPW = 4
) (
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
        T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
        RESET = 4'd8, PAUSE = 4'd9, HALT = 4'd10
    } state_t;

    localparam logic [OPW-1:0] OP_ADD = OPW'(3);

    state_t         stateReg, stateNext, lastStep;
    logic [OPW-1:0] opcode;
    logic isLd, isLdi, isSt, isAlu, isImm, isMulDiv, isNeg, isMfhi, isMflo, isHalt;
    logic memWait;

    assign opcode = bus.ir[31 -: OPW];

    always_comb begin
        isLd     = (opcode == OPW'(0));
        isLdi    = (opcode == OPW'(1));
        isSt     = (opcode == OPW'(2));
        isAlu    = (opcode >= OPW'(3))  && (opcode <= OPW'(10));
        isImm    = (opcode >= OPW'(11)) && (opcode <= OPW'(13));
        isMulDiv = (opcode == OPW'(14)) || (opcode == OPW'(15));
        isNeg    = (opcode == OPW'(16)) || (opcode == OPW'(17));
        isMfhi   = (opcode == OPW'(23));
        isMflo   = (opcode == OPW'(24));
        isHalt   = (opcode == OPW'(27));
        // nop and undefined opcodes fall through to a single empty T3
        lastStep = T3;
        if (isLd || isSt)                lastStep = T7;
        else if (isLdi || isAlu || isImm) lastStep = T5;
        else if (isMulDiv)               lastStep = T6;
        else if (isNeg)                  lastStep = T4;
        memWait = (stateReg == T1) || (stateReg == T6 && isLd) || (stateReg == T7 && isSt);
    end

    always_ff @(posedge clock) begin
        if (clear) stateReg <= RESET;
        else       stateReg <= stateNext;
    end

    always_comb begin
        stateNext = RESET;
        case (stateReg)
            RESET: stateNext = T0;
            PAUSE: stateNext = bus.stop ? PAUSE : T0;
            HALT:  stateNext = HALT;
            T0:    stateNext = T1;
            T1:    stateNext = bus.mem_ready ? T2 : T1;
            T2:    stateNext = T3;
            T3, T4, T5, T6, T7: begin
                if (memWait && !bus.mem_ready) stateNext = stateReg;
                else if (stateReg >= lastStep) stateNext = isHalt ? HALT : (bus.stop ? PAUSE : T0);
                else                           stateNext = state_t'(stateReg + 4'd1);
            end
            default: stateNext = RESET;
        endcase
    end

    always_comb begin
        bus.run    = (stateReg <= T7);
        bus.step   = STEPW'(stateReg);
        bus.alu_op = '0;
        {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.HIout, bus.LOout, bus.Cout, bus.BAout} = '0;
        {bus.PCin, bus.MARin, bus.MDRin, bus.IRin, bus.Yin, bus.Zin, bus.HIin, bus.LOin, bus.Rin} = '0;
        {bus.IncPC, bus.Read, bus.Write, bus.Gra, bus.Grb, bus.Grc, bus.Rout} = '0;
        case (stateReg)
            T0: {bus.PCout, bus.MARin, bus.IncPC, bus.Zin} = '1;
            // PCin stays up through a memory stall; Z is unchanged so reloading PC is harmless
            T1: {bus.Zlowout, bus.PCin, bus.Read, bus.MDRin} = '1;
            T2: {bus.MDRout, bus.IRin} = '1;
            T3: begin
                if (isLd || isLdi || isSt)  {bus.Grb, bus.BAout, bus.Yin} = '1;
                else if (isAlu || isImm)    {bus.Grb, bus.Rout, bus.Yin} = '1;
                else if (isMulDiv)          {bus.Gra, bus.Rout, bus.Yin} = '1;
                else if (isNeg) begin
                    {bus.Grb, bus.Rout, bus.Zin} = '1;
                    bus.alu_op = opcode;
                end
                else if (isMfhi)            {bus.HIout, bus.Gra, bus.Rin} = '1;
                else if (isMflo)            {bus.LOout, bus.Gra, bus.Rin} = '1;
            end
            T4: begin
                if (isLd || isLdi || isSt) begin
                    {bus.Cout, bus.Zin} = '1;
                    bus.alu_op = OP_ADD;
                end
                else if (isAlu) begin
                    {bus.Grc, bus.Rout, bus.Zin} = '1;
                    bus.alu_op = opcode;
                end
                else if (isImm) begin
                    {bus.Cout, bus.Zin} = '1;
                    bus.alu_op = opcode;
                end
                else if (isMulDiv) begin
                    {bus.Grb, bus.Rout, bus.Zin} = '1;
                    bus.alu_op = opcode;
                end
                else if (isNeg)             {bus.Zlowout, bus.Gra, bus.Rin} = '1;
            end
            T5: begin
                if (isLd || isSt)                   {bus.Zlowout, bus.MARin} = '1;
                else if (isLdi || isAlu || isImm)   {bus.Zlowout, bus.Gra, bus.Rin} = '1;
                else if (isMulDiv)                  {bus.Zlowout, bus.LOin} = '1;
            end
            T6: begin
                if (isLd)           {bus.Read, bus.MDRin} = '1;
                else if (isSt)      {bus.Gra, bus.Rout, bus.MDRin} = '1;
                else if (isMulDiv)  {bus.Zhighout, bus.HIin} = '1;
            end
            T7: begin
                if (isLd)           {bus.MDRout, bus.Gra, bus.Rin} = '1;
                else if (isSt)      bus.Write = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: each task walks one instruction
// scenario cycle by cycle against a hand-written table of expected outputs.
module tb_control_sequencer;
    logic clock = 1'b0;
    logic clear = 1'b1;
    int checks = 0;
    int errors = 0;

    control_sequencer_if #(.OPW(5), .STEPW(4)) bus ();
    control_sequencer #(.OPW(5), .STEPW(4)) dut (.clock(clock), .clear(clear), .bus(bus));

    always #5 clock = ~clock;

    localparam logic [23:0] PCOUT = 24'd1 << 23, ZLOW = 24'd1 << 22, ZHIGH = 24'd1 << 21,
        MDROUT = 24'd1 << 20, HIOUT = 24'd1 << 19, LOOUT = 24'd1 << 18, COUT = 24'd1 << 17,
        BAOUT = 24'd1 << 16, PCIN = 24'd1 << 15, MARIN = 24'd1 << 14, MDRIN = 24'd1 << 13,
        IRIN = 24'd1 << 12, YIN = 24'd1 << 11, ZIN = 24'd1 << 10, HIIN = 24'd1 << 9,
        LOIN = 24'd1 << 8, RIN = 24'd1 << 7, INCPC = 24'd1 << 6, READ = 24'd1 << 5,
        WRITE = 24'd1 << 4, GRA = 24'd1 << 3, GRB = 24'd1 << 2, GRC = 24'd1 << 1, ROUT = 24'd1;

    function automatic logic [33:0] e(input logic [3:0] s, input logic r, input logic [4:0] a,
                                      input logic [23:0] sb);
        return {s, r, a, sb};
    endfunction

    function automatic logic [33:0] obs();
        return {bus.step, bus.run, bus.alu_op,
                bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.HIout, bus.LOout, bus.Cout,
                bus.BAout, bus.PCin, bus.MARin, bus.MDRin, bus.IRin, bus.Yin, bus.Zin, bus.HIin,
                bus.LOin, bus.Rin, bus.IncPC, bus.Read, bus.Write, bus.Gra, bus.Grb, bus.Grc,
                bus.Rout};
    endfunction

    logic [33:0] F0, F1, F2, RST, PSE, HLT;
    initial begin
        F0  = e(4'd0, 1'b1, 5'd0, PCOUT | MARIN | INCPC | ZIN);
        F1  = e(4'd1, 1'b1, 5'd0, ZLOW | PCIN | READ | MDRIN);
        F2  = e(4'd2, 1'b1, 5'd0, MDROUT | IRIN);
        RST = e(4'd8, 1'b0, 5'd0, 24'd0);
        PSE = e(4'd9, 1'b0, 5'd0, 24'd0);
        HLT = e(4'd10, 1'b0, 5'd0, 24'd0);
    end

    task automatic test_reset();
        logic [2:0]  sv[$];
        logic [33:0] ev[$];
        sv = '{3'b101, 3'b101, 3'b001};
        ev = '{RST, RST, F0};
        for (int i = 0; i < ev.size(); i++) begin
            {clear, bus.stop, bus.mem_ready} = sv[i];
            @(posedge clock); @(negedge clock);
            checks++;
            if (obs() !== ev[i]) begin
                errors++;
                $display("FAIL reset[%0d] got=%h want=%h", i, obs(), ev[i]);
            end else $display("reset[%0d] step=%0d ok", i, bus.step);
        end
    endtask

    task automatic test_add();
        logic [2:0]  sv[$];
        logic [33:0] ev[$];
        bus.ir = 32'h1A920000;
        sv = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        ev = '{F1, F2, e(4'd3, 1'b1, 5'd0, GRB | ROUT | YIN), e(4'd4, 1'b1, 5'd3, GRC | ROUT | ZIN),
               e(4'd5, 1'b1, 5'd0, ZLOW | GRA | RIN), F0};
        for (int i = 0; i < ev.size(); i++) begin
            {clear, bus.stop, bus.mem_ready} = sv[i];
            @(posedge clock); @(negedge clock);
            checks++;
            if (obs() !== ev[i]) begin
                errors++;
                $display("FAIL add[%0d] got=%h want=%h", i, obs(), ev[i]);
            end else $display("add[%0d] step=%0d ok", i, bus.step);
        end
    endtask

    task automatic test_ld_wait();
        logic [2:0]  sv[$];
        logic [33:0] ev[$];
        bus.ir = 32'h00880005;
        sv = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001};
        ev = '{F1, F2, e(4'd3, 1'b1, 5'd0, GRB | BAOUT | YIN), e(4'd4, 1'b1, 5'd3, COUT | ZIN),
               e(4'd5, 1'b1, 5'd0, ZLOW | MARIN),
               e(4'd6, 1'b1, 5'd0, READ | MDRIN), e(4'd6, 1'b1, 5'd0, READ | MDRIN),
               e(4'd6, 1'b1, 5'd0, READ | MDRIN), e(4'd6, 1'b1, 5'd0, READ | MDRIN),
               e(4'd7, 1'b1, 5'd0, MDROUT | GRA | RIN), F0};
        for (int i = 0; i < ev.size(); i++) begin
            {clear, bus.stop, bus.mem_ready} = sv[i];
            @(posedge clock); @(negedge clock);
            checks++;
            if (obs() !== ev[i]) begin
                errors++;
                $display("FAIL ld[%0d] got=%h want=%h", i, obs(), ev[i]);
            end else $display("ld[%0d] step=%0d ok", i, bus.step);
        end
    endtask

    task automatic test_st_wait();
        logic [2:0]  sv[$];
        logic [33:0] ev[$];
        bus.ir = 32'h10000000;
        sv = '{3'b001, 3'b000, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b001};
        ev = '{F1, F1, F2, e(4'd3, 1'b1, 5'd0, GRB | BAOUT | YIN), e(4'd4, 1'b1, 5'd3, COUT | ZIN),
               e(4'd5, 1'b1, 5'd0, ZLOW | MARIN), e(4'd6, 1'b1, 5'd0, GRA | ROUT | MDRIN),
               e(4'd7, 1'b1, 5'd0, WRITE), e(4'd7, 1'b1, 5'd0, WRITE), F0};
        for (int i = 0; i < ev.size(); i++) begin
            {clear, bus.stop, bus.mem_ready} = sv[i];
            @(posedge clock); @(negedge clock);
            checks++;
            if (obs() !== ev[i]) begin
                errors++;
                $display("FAIL st[%0d] got=%h want=%h", i, obs(), ev[i]);
            end else $display("st[%0d] step=%0d ok", i, bus.step);
        end
    endtask

    task automatic test_mul();
        logic [2:0]  sv[$];
        logic [33:0] ev[$];
        bus.ir = 32'h70000000;
        sv = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        ev = '{F1, F2, e(4'd3, 1'b1, 5'd0, GRA | ROUT | YIN), e(4'd4, 1'b1, 5'd14, GRB | ROUT | ZIN),
               e(4'd5, 1'b1, 5'd0, ZLOW | LOIN), e(4'd6, 1'b1, 5'd0, ZHIGH | HIIN), F0};
        for (int i = 0; i < ev.size(); i++) begin
            {clear, bus.stop, bus.mem_ready} = sv[i];
            @(posedge clock); @(negedge clock);
            checks++;
            if (obs() !== ev[i]) begin
                errors++;
                $display("FAIL mul[%0d] got=%h want=%h", i, obs(), ev[i]);
            end else $display("mul[%0d] step=%0d ok", i, bus.step);
        end
    endtask

    task automatic test_stop_pause();
        logic [2:0]  sv[$];
        logic [33:0] ev[$];
        bus.ir = 32'h1A920000;
        sv = '{3'b001, 3'b001, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b001};
        ev = '{F1, F2, e(4'd3, 1'b1, 5'd0, GRB | ROUT | YIN), e(4'd4, 1'b1, 5'd3, GRC | ROUT | ZIN),
               e(4'd5, 1'b1, 5'd0, ZLOW | GRA | RIN), PSE, PSE, F0};
        for (int i = 0; i < ev.size(); i++) begin
            {clear, bus.stop, bus.mem_ready} = sv[i];
            @(posedge clock); @(negedge clock);
            checks++;
            if (obs() !== ev[i]) begin
                errors++;
                $display("FAIL pause[%0d] got=%h want=%h", i, obs(), ev[i]);
            end else $display("pause[%0d] step=%0d ok", i, bus.step);
        end
    endtask

    task automatic test_halt();
        logic [2:0]  sv[$];
        logic [33:0] ev[$];
        bus.ir = 32'hD8000000;
        sv = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b011, 3'b001, 3'b011, 3'b101, 3'b001};
        ev = '{F1, F2, e(4'd3, 1'b1, 5'd0, 24'd0), HLT, HLT, HLT, HLT, RST, F0};
        for (int i = 0; i < ev.size(); i++) begin
            {clear, bus.stop, bus.mem_ready} = sv[i];
            @(posedge clock); @(negedge clock);
            checks++;
            if (obs() !== ev[i]) begin
                errors++;
                $display("FAIL halt[%0d] got=%h want=%h", i, obs(), ev[i]);
            end else $display("halt[%0d] step=%0d ok", i, bus.step);
        end
    endtask

    task automatic test_clear_abort();
        logic [2:0]  sv[$];
        logic [33:0] ev[$];
        bus.ir = 32'h1A920000;
        sv = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b101, 3'b001};
        ev = '{F1, F2, e(4'd3, 1'b1, 5'd0, GRB | ROUT | YIN), e(4'd4, 1'b1, 5'd3, GRC | ROUT | ZIN),
               RST, F0};
        for (int i = 0; i < ev.size(); i++) begin
            {clear, bus.stop, bus.mem_ready} = sv[i];
            @(posedge clock); @(negedge clock);
            checks++;
            if (obs() !== ev[i]) begin
                errors++;
                $display("FAIL abort[%0d] got=%h want=%h", i, obs(), ev[i]);
            end else $display("abort[%0d] step=%0d ok", i, bus.step);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] iv[$];
        logic [33:0] ev[$];
        iv = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
               32'hB8000000, 32'hB8000000, 32'hB8000000, 32'hB8000000,
               32'h08000000, 32'h08000000, 32'h08000000, 32'h08000000, 32'h08000000, 32'h08000000};
        ev = '{F1, F2, e(4'd3, 1'b1, 5'd16, GRB | ROUT | ZIN), e(4'd4, 1'b1, 5'd0, ZLOW | GRA | RIN), F0,
               F1, F2, e(4'd3, 1'b1, 5'd0, HIOUT | GRA | RIN), F0,
               F1, F2, e(4'd3, 1'b1, 5'd0, GRB | BAOUT | YIN), e(4'd4, 1'b1, 5'd3, COUT | ZIN),
               e(4'd5, 1'b1, 5'd0, ZLOW | GRA | RIN), F0};
        for (int i = 0; i < ev.size(); i++) begin
            {clear, bus.stop, bus.mem_ready} = 3'b001;
            bus.ir = iv[i];
            @(posedge clock); @(negedge clock);
            checks++;
            if (obs() !== ev[i]) begin
                errors++;
                $display("FAIL b2b[%0d] got=%h want=%h", i, obs(), ev[i]);
            end else $display("b2b[%0d] step=%0d ok", i, bus.step);
        end
    endtask

    initial begin
        bus.ir = 32'h0;
        bus.mem_ready = 1'b0;
        bus.stop = 1'b0;
        @(negedge clock);
        test_reset();
        test_add();
        test_ld_wait();
        test_st_wait();
        test_mul();
        test_stop_pause();
        test_halt();
        test_clear_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
